// File: rtl/merge_scheduler.sv
// Merge-select sequencer for the 257-point NTT output merger.
// Each level runs a BFA_LAT-cycle butterfly phase, then a primed two-cycle twiddle phase.
// All outputs come from registers; load_en is the registered load slot masked by hold.
module merge_scheduler #(
    parameter int unsigned BFA_LAT    = 4,
    parameter int unsigned NUM_LEVELS = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       mul_last_i,
    input  logic       hold_i,
    output logic [2:0] merge_sel_o,
    output logic       load_en_o,
    output logic [1:0] level_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {StIdle, StBfa, StMul0, StMul1, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast     = CNT_W'(BFA_LAT - 1);
    localparam logic [1:0]       LevelLast   = 2'(NUM_LEVELS - 1);
    // With a one-cycle butterfly phase the very first BFA cycle is already the load slot.
    localparam bit               LoadOnFirst = (BFA_LAT == 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       level_q;
    logic             mul_last_q;
    logic [2:0]       sel_q;
    logic             load_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       level_inc;

    // Increment helpers for the butterfly counter and level index.
    always_comb begin
        cnt_inc   = cnt_q + CNT_W'(1);
        level_inc = level_q + 2'd1;
    end

    // Sequencer FSM; every output register is loaded alongside its state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            level_q    <= 2'd0;
            mul_last_q <= 1'b0;
            sel_q      <= 3'd0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StBfa;
                        level_q    <= 2'd0;
                        cnt_q      <= '0;
                        mul_last_q <= mul_last_i;
                        sel_q      <= 3'd0;
                        load_q     <= LoadOnFirst;
                        busy_q     <= 1'b1;
                    end
                end
                StBfa: begin
                    // A held cycle freezes everything, so the load slot is replayed later.
                    if (!hold_i) begin
                        if (cnt_q == CntLast) begin
                            load_q <= 1'b0;
                            if (level_q == LevelLast && !mul_last_q) begin
                                state_q <= StDone;
                                sel_q   <= 3'd0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StMul0;
                                cnt_q   <= '0;
                                sel_q   <= {1'b1, level_q};
                            end
                        end else begin
                            cnt_q  <= cnt_inc;
                            load_q <= (cnt_inc == CntLast);
                        end
                    end
                end
                StMul0: begin
                    if (!hold_i) begin
                        state_q <= StMul1;
                        load_q  <= 1'b1;
                    end
                end
                StMul1: begin
                    if (hold_i) begin
                        // Previous-adder register moved on; the merger must be primed again.
                        state_q <= StMul0;
                        load_q  <= 1'b0;
                    end else if (level_q == LevelLast) begin
                        state_q <= StDone;
                        sel_q   <= 3'd0;
                        load_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StBfa;
                        level_q <= level_inc;
                        cnt_q   <= '0;
                        sel_q   <= {1'b0, level_inc};
                        load_q  <= LoadOnFirst;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    level_q <= 2'd0;
                    sel_q   <= 3'd0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    level_q <= 2'd0;
                    sel_q   <= 3'd0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output drive; a hold suppresses the pending load slot in the same cycle.
    always_comb begin
        merge_sel_o = sel_q;
        load_en_o   = load_q & ~hold_i;
        level_o     = level_q;
        busy_o      = busy_q;
        done_o      = done_q;
    end

endmodule
